// File: rtl/cva5_types.sv
// Shared CVA5 core types: ID space, writeback, retire and trace packets.
package cva5_types;
   localparam int unsigned MAX_IDS = 8;

   typedef logic [$clog2(MAX_IDS)-1:0] id_t;

   typedef struct packed {
      logic        valid;
      id_t         id;
      logic [31:0] data;
   } wb_packet_t;

   typedef struct packed {
      logic valid;
      id_t  id;
   } retire_packet_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instruction;
   } trace_retire_outputs_t;
endpackage

// File: rtl/retire_order_tracker_pkg.sv
// Constants and helpers local to the retire order tracker.
package retire_order_tracker_pkg;
   import cva5_types::*;

   localparam int unsigned DEFAULT_NUM_WB_PORTS = 2;

   function automatic logic [MAX_IDS-1:0] id_mask(input id_t id);
      id_mask     = '0;
      id_mask[id] = 1'b1;
   endfunction
endpackage

// File: rtl/retire_order_queue.sv
// Head/tail pointer circular buffer control with wrap bits; occupancy is derived from the pointers.
module retire_order_queue #(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned IDX_W = $clog2(DEPTH)
)(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [IDX_W-1:0] head_idx_o,
   output logic [IDX_W-1:0] tail_idx_o,
   output logic [IDX_W:0]   count_o,
   output logic             full_o,
   output logic             empty_o
);
   logic [IDX_W:0] head_q, head_d, tail_q, tail_d;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (pop_i)  head_d = head_q + (IDX_W+1)'(1);
      if (push_i) tail_d = tail_q + (IDX_W+1)'(1);
      if (flush_i) begin
         head_d = '0;
         tail_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   assign head_idx_o = head_q[IDX_W-1:0];
   assign tail_idx_o = tail_q[IDX_W-1:0];
   // Modulo-2*DEPTH difference yields 0..DEPTH thanks to the wrap bit.
   assign count_o    = tail_q - head_q;
   assign empty_o    = (head_q == tail_q);
   assign full_o     = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
endmodule

// File: rtl/retire_order_tracker.sv
// In-order retirement tracker: program-ordered queue plus per-ID completion bitmap.
// Define RETIRE_TRACE_EN to add the trace port and per-entry pc/instruction storage.
module retire_order_tracker
   import cva5_types::*;
   import retire_order_tracker_pkg::*;
#(
   parameter int unsigned NUM_WB_PORTS = DEFAULT_NUM_WB_PORTS,
   parameter int unsigned DEPTH        = MAX_IDS
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  issue_valid,
   output logic                  issue_ready,
   input  id_t                   issue_id,
   input  logic                  issue_no_wb,
   input  logic [31:0]           issue_pc,
   input  logic [31:0]           issue_instruction,
   input  wb_packet_t            wb [NUM_WB_PORTS],
   input  logic                  flush,
   output retire_packet_t        retire,
`ifdef RETIRE_TRACE_EN
   output trace_retire_outputs_t trace,
`endif
   output logic [$clog2(DEPTH):0] retire_count
);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   typedef struct packed {
      id_t         id;
`ifdef RETIRE_TRACE_EN
      logic [31:0] pc;
      logic [31:0] instruction;
`endif
   } entry_t;

   entry_t             entries_q [DEPTH];
   entry_t             new_entry, head_entry;
   logic [MAX_IDS-1:0] done_q, done_d, inflight_q, inflight_d;
   logic [IDX_W-1:0]   head_idx, tail_idx;
   logic               full, empty, push, pop;

   retire_order_queue #(.DEPTH(DEPTH)) u_queue (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .push_i     (push),
      .pop_i      (pop),
      .flush_i    (flush),
      .head_idx_o (head_idx),
      .tail_idx_o (tail_idx),
      .count_o    (retire_count),
      .full_o     (full),
      .empty_o    (empty)
   );

   assign issue_ready = ~full;
   assign push        = issue_valid & issue_ready & ~flush;
   assign head_entry  = entries_q[head_idx];
   assign pop         = ~empty & done_q[head_entry.id] & ~flush;

   assign retire.valid = pop;
   assign retire.id    = head_entry.id;

   always_comb begin
      new_entry             = '0;
      new_entry.id          = issue_id;
`ifdef RETIRE_TRACE_EN
      new_entry.pc          = issue_pc;
      new_entry.instruction = issue_instruction;
`endif
   end

   always_ff @(posedge clk) begin
      if (push) entries_q[tail_idx] <= new_entry;
   end

   // Order matters: writebacks, then retire clears, then the new issue claims its ID.
   always_comb begin
      done_d     = done_q;
      inflight_d = inflight_q;
      for (int unsigned i = 0; i < NUM_WB_PORTS; i++) begin
         if (wb[i].valid && inflight_q[wb[i].id]) done_d = done_d | id_mask(wb[i].id);
      end
      if (pop) begin
         done_d     = done_d & ~id_mask(head_entry.id);
         inflight_d = inflight_d & ~id_mask(head_entry.id);
      end
      if (push) begin
         inflight_d = inflight_d | id_mask(issue_id);
         if (issue_no_wb) done_d = done_d | id_mask(issue_id);
         else             done_d = done_d & ~id_mask(issue_id);
      end
      if (flush) begin
         done_d     = '0;
         inflight_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q     <= '0;
         inflight_q <= '0;
      end else begin
         done_q     <= done_d;
         inflight_q <= inflight_d;
      end
   end

`ifdef RETIRE_TRACE_EN
   assign trace.valid       = pop;
   assign trace.pc          = head_entry.pc;
   assign trace.instruction = head_entry.instruction;
`endif

   logic unused_inputs;
   always_comb begin
      unused_inputs = 1'b0;
      for (int unsigned i = 0; i < NUM_WB_PORTS; i++) unused_inputs = unused_inputs ^ (^wb[i].data);
`ifndef RETIRE_TRACE_EN
      unused_inputs = unused_inputs ^ (^{issue_pc, issue_instruction});
`endif
   end
endmodule

// File: doc/retire_order_tracker.md
RETIRE_ORDER_TRACKER -- requirements
Module: retire_order_tracker

Interface
REQ-001 Parameter NUM_WB_PORTS, default 2: number of writeback completion ports.
REQ-002 Parameter DEPTH, default MAX_IDS: tracker entries; power of two; equals ID space size.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port issue_valid  input  1  instruction issued this cycle.
REQ-006 Port issue_ready  output  1  tracker can accept an issue.
REQ-007 Port issue_id  input  id_t  ID of issued instruction.
REQ-008 Port issue_no_wb  input  1  instruction has no writeback (store, branch); complete at issue.
REQ-009 Port issue_pc, issue_instruction  input  32 each  trace payload.
REQ-010 Port wb  input  wb_packet_t[NUM_WB_PORTS]  completion reports (valid, id; data ignored).
REQ-011 Port flush  input  1  gc writeback_suppress/flush; discard all tracked instructions.
REQ-012 Port retire  output  retire_packet_t  oldest completed instruction retiring this cycle.
REQ-013 Port retire_count  output  $clog2(DEPTH)+1  entries currently tracked.

Function
REQ-014 Circular queue of DEPTH entries (id, done, trace payload), head/tail pointers with extra wrap bit.
REQ-015 issue_ready = (count != DEPTH), from registered count only; a same-cycle retire does not free a slot.
REQ-016 issue_valid & issue_ready: write entry at tail, tail+1; done = issue_no_wb.
REQ-017 issue_valid while !issue_ready: ignored, no state change.
REQ-018 Completion tracked in per-ID done bitmap of MAX_IDS bits, indexed by id.
REQ-019 wb[i].valid sets done[wb[i].id]; multiple ports may set different IDs same cycle; duplicate IDs across ports are equivalent to one.
REQ-020 wb for an ID not currently tracked: ignored; no bit set.
REQ-021 retire.valid = (count != 0) & done[head id] & !flush; retire.id = head id; combinational from registered state.
REQ-022 Minimum latency: wb at cycle N -> retire.valid at N+1; issue_no_wb at N -> retire at N+1.
REQ-023 On retire: head+1, done bit of retired ID cleared; one retire per cycle max.
REQ-024 Simultaneous issue and retire: count unchanged; both pointers advance.
REQ-025 Pointer wrap: index wraps DEPTH-1 -> 0; wrap bit toggles; full = indices equal & wrap bits differ.
REQ-026 flush: next cycle head = tail = 0, count = 0, all done bits 0; issue and wb in flush cycle discarded; retire.valid = 0 in flush cycle.
REQ-027 Entries strictly in program order; out-of-order completion never reorders retirement.

Reset
REQ-028 rst_n low: head = tail = 0, count = 0, done bitmap = 0, retire.valid = 0, issue_ready = 1, asynchronously.
REQ-029 Reset mid-operation discards all entries; no retire emitted during or in first cycle after deassertion.
REQ-030 Entry payload RAM is not reset.

Configuration
REQ-031 Macro RETIRE_TRACE_EN defined: output trace  trace_retire_outputs_t; trace.valid = retire.valid; pc/instruction from head entry; reset value valid = 0.
REQ-032 RETIRE_TRACE_EN undefined: no trace port, no pc/instruction storage; issue_pc/issue_instruction unused.

Structure
REQ-033 id_t, wb_packet_t, retire_packet_t, trace_retire_outputs_t, MAX_IDS come from the shared cva5_types package; no new package typedefs.
REQ-034 Local typedef for queue entry stays inside the module.
REQ-035 One sub-module: retire_order_queue (pointer/count circular buffer); done bitmap and retire logic in top.

Verification
REQ-036 Issue IDs 0,1,2 (wb type), wb IDs 2,1,0 on successive cycles -> retire IDs 0,1,2 on three consecutive cycles starting one cycle after wb of ID 0.
REQ-037 Fill DEPTH=8 entries, none complete -> issue_ready=0, count=8; extra issue ignored; complete head -> retire next cycle, issue_ready=1 following cycle.
REQ-038 Issue ID 3 with issue_no_wb=1 at cycle N -> retire.valid, id=3 at N+1.
REQ-039 Two ports wb IDs 4 and 5 same cycle, queue head 4 then 5 -> retires 4 then 5 on consecutive cycles.
REQ-040 5 entries tracked, flush asserted with concurrent wb and issue -> retire.valid=0 that cycle, count=0 next cycle, no later retire of flushed IDs.
REQ-041 Run 3*DEPTH issue/retire pairs across wrap; with RETIRE_TRACE_EN, trace pc/instruction match issue order each retire.
